// File: rtl/status_tx_pkg.sv
// Shared command encoding: control codes, their ASCII letters, frame characters and helpers.
// The inbound decoder and the outbound reporter both import this mapping.
package status_tx_pkg;

  typedef enum logic [2:0] {
    CTRL_NONE       = 3'd0,
    CTRL_LEFT       = 3'd1,
    CTRL_RIGHT      = 3'd2,
    CTRL_DOWN       = 3'd3,
    CTRL_DROP       = 3'd4,
    CTRL_HOLD       = 3'd5,
    CTRL_ROTATE     = 3'd6,
    CTRL_ROTATE_REV = 3'd7
  } control_type;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND    = 2'd1,
    ST_WAIT_HI = 2'd2,
    ST_WAIT_LO = 2'd3
  } tx_state_t;

  localparam logic [7:0] ASCII_LEFT       = 8'h61;  // 'a'
  localparam logic [7:0] ASCII_RIGHT      = 8'h64;  // 'd'
  localparam logic [7:0] ASCII_DOWN       = 8'h77;  // 'w'
  localparam logic [7:0] ASCII_DROP       = 8'h73;  // 's'
  localparam logic [7:0] ASCII_HOLD       = 8'h63;  // 'c'
  localparam logic [7:0] ASCII_ROTATE     = 8'h78;  // 'x'
  localparam logic [7:0] ASCII_ROTATE_REV = 8'h7A;  // 'z'
  localparam logic [7:0] ASCII_S          = 8'h53;
  localparam logic [7:0] ASCII_CR         = 8'h0D;
  localparam logic [7:0] ASCII_LF         = 8'h0A;

  function automatic logic [7:0] control_to_ascii(input control_type code);
    logic [7:0] ch;
    case (code)
      CTRL_LEFT:       ch = ASCII_LEFT;
      CTRL_RIGHT:      ch = ASCII_RIGHT;
      CTRL_DOWN:       ch = ASCII_DOWN;
      CTRL_DROP:       ch = ASCII_DROP;
      CTRL_HOLD:       ch = ASCII_HOLD;
      CTRL_ROTATE:     ch = ASCII_ROTATE;
      CTRL_ROTATE_REV: ch = ASCII_ROTATE_REV;
      default:         ch = 8'h00;
    endcase
    return ch;
  endfunction

  function automatic logic [7:0] nibble_to_hex(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

endpackage

// File: rtl/status_tx_sync_fifo.sv
// sync_fifo: single-clock FIFO, combinational read of the head entry.
// Push while full and pop while empty are ignored; a same-cycle pop never frees room for a push.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_dout
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_dout    = r_mem[r_rd_ptr];
  assign w_push_ok = i_push & ~o_full;
  assign w_pop_ok  = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/status_tx.sv
// status_tx: sends queued command letters and atomic "S"+4-hex score frames to the shared UART.
// Define STATUS_TX_CRLF_EN to append CR LF to every score frame (7 bytes instead of 5).
import status_tx_pkg::*;

module status_tx #(
  parameter int FIFO_DEPTH = 8,
  parameter int SCORE_W    = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               evt_valid,
  input  control_type        evt_code,
  output logic               evt_ready,
  input  logic               score_req,
  input  logic [SCORE_W-1:0] score,
  input  logic               is_transmitting,
  output logic               transmit,
  output logic [7:0]         tx_byte,
  output logic               busy,
  output logic               overflow
);

`ifdef STATUS_TX_CRLF_EN
  localparam logic [2:0] LAST_IDX = 3'd6;
`else
  localparam logic [2:0] LAST_IDX = 3'd4;
`endif

  tx_state_t          r_state;
  tx_state_t          w_state_nxt;
  logic [SCORE_W-1:0] r_score;
  logic               r_score_pend;
  logic               r_in_frame;
  logic [2:0]         r_idx;
  logic [7:0]         r_tx_byte;
  logic               r_overflow;

  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic [7:0]         w_evt_byte;
  logic [7:0]         w_fifo_dout;
  logic [2:0]         w_idx_inc;
  logic [7:0]         w_frame_byte;
  logic [7:0]         w_tx_byte_nxt;
  logic [2:0]         w_idx_nxt;
  logic               w_frame_start;
  logic               w_frame_end;

  // NONE is accepted (consumes the handshake) but never queued.
  assign w_push     = evt_valid & ~w_full & (evt_code != CTRL_NONE);
  assign w_evt_byte = control_to_ascii(evt_code);

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .i_push (w_push),
    .i_din  (w_evt_byte),
    .i_pop  (w_pop),
    .o_full (w_full),
    .o_empty(w_empty),
    .o_dout (w_fifo_dout)
  );

  assign w_idx_inc = r_idx + 3'd1;

  always_comb begin
    w_frame_byte = 8'h00;
    case (w_idx_inc)
      3'd1:    w_frame_byte = nibble_to_hex(r_score[15:12]);
      3'd2:    w_frame_byte = nibble_to_hex(r_score[11:8]);
      3'd3:    w_frame_byte = nibble_to_hex(r_score[7:4]);
      3'd4:    w_frame_byte = nibble_to_hex(r_score[3:0]);
      3'd5:    w_frame_byte = ASCII_CR;
      3'd6:    w_frame_byte = ASCII_LF;
      default: w_frame_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (r_score_pend || !w_empty) w_state_nxt = ST_SEND;
      ST_SEND:    w_state_nxt = ST_WAIT_HI;
      ST_WAIT_HI: if (is_transmitting) w_state_nxt = ST_WAIT_LO;
      ST_WAIT_LO: begin
        if (!is_transmitting)
          w_state_nxt = (r_in_frame && r_idx != LAST_IDX) ? ST_SEND : ST_IDLE;
      end
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_pop         = 1'b0;
    w_tx_byte_nxt = r_tx_byte;
    w_idx_nxt     = r_idx;
    w_frame_start = 1'b0;
    w_frame_end   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // A pending score frame wins over queued events.
        if (r_score_pend) begin
          w_frame_start = 1'b1;
          w_tx_byte_nxt = ASCII_S;
          w_idx_nxt     = 3'd0;
        end else if (!w_empty) begin
          w_pop         = 1'b1;
          w_tx_byte_nxt = w_fifo_dout;
        end
      end
      ST_WAIT_LO: begin
        if (!is_transmitting && r_in_frame) begin
          if (r_idx != LAST_IDX) begin
            w_idx_nxt     = w_idx_inc;
            w_tx_byte_nxt = w_frame_byte;
          end else begin
            w_idx_nxt   = 3'd0;
            w_frame_end = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_score      <= '0;
      r_score_pend <= 1'b0;
      r_in_frame   <= 1'b0;
      r_idx        <= 3'd0;
      r_tx_byte    <= 8'h00;
      r_overflow   <= 1'b0;
    end else begin
      r_tx_byte  <= w_tx_byte_nxt;
      r_idx      <= w_idx_nxt;
      r_overflow <= r_overflow | (evt_valid & w_full);
      if (w_frame_start)    r_in_frame <= 1'b1;
      else if (w_frame_end) r_in_frame <= 1'b0;
      // score_pend stays set for the whole frame, so later requests coalesce.
      if (w_frame_end) begin
        r_score_pend <= 1'b0;
      end else if (score_req && !r_score_pend) begin
        r_score_pend <= 1'b1;
        r_score      <= score;
      end
    end
  end

  assign transmit  = (r_state == ST_SEND);
  assign tx_byte   = r_tx_byte;
  assign evt_ready = ~w_full;
  assign busy      = (r_state != ST_IDLE) | r_score_pend | ~w_empty;
  assign overflow  = r_overflow;

endmodule
